// File: rtl/adder_bist_driver.sv
// ---------------------------------------------------------------------------
// adder_bist_driver
//
// Built-in self-test initiator for the 2-bit adder. On an accepted start it
// sweeps all 16 operand combinations PASSES times. Each vector is held for
// LATENCY+1 cycles, and the adder response is checked on the last cycle of
// that hold. It reports a pass flag, a saturating mismatch count and the
// first failing vector.
//
// Parameters:
//   LATENCY   adder latency in cycles, from operand to valid response (0..7)
//   PASSES    number of full 16-vector sweeps per run (1..4)
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   start       run request, sampled only in IDLE or DONE
//   a,b,c,d     registered operand drive: A = {a,b}, B = {c,d}
//   v..z        adder response {v,w,x,y,z}, with v as the MSB
//   busy        high while the sweep is running
//   done        high from run completion until the next accepted start
//   pass        1 = no mismatches; meaningful only while done = 1
//   err_count   mismatch count of the current run, saturates at 31
//   first_fail  {a,b,c,d} of the first mismatching vector (0 if none)
// ---------------------------------------------------------------------------
module adder_bist_driver #(
  parameter int LATENCY = 1,
  parameter int PASSES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       v,
  input  logic       w,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAT_C  = 3'(LATENCY);
  localparam logic [2:0] PASS_C = 3'(PASSES);

  state_t     state, state_n;
  logic [3:0] vec, vec_n;       // current vector; doubles as the a..d register
  logic [2:0] hold, hold_n;     // cycles spent on the current vector
  logic [2:0] pcnt, pcnt_n;     // completed sweeps
  logic [4:0] err_n;
  logic [3:0] ff_n;
  logic       pass_n;

  logic [4:0] resp;
  logic [4:0] expected;
  logic       mismatch;

  assign resp     = {v, w, x, y, z};
  // The 3-bit sum of the two 2-bit operands, zero-extended to 5 bits.
  assign expected = {2'b00, {1'b0, vec[3:2]} + {1'b0, vec[1:0]}};
  assign mismatch = (resp != expected);

  // vec returns to 0 whenever the sweep is not running, so a..d read 0 in
  // IDLE and DONE without any extra gating.
  assign {a, b, c, d} = vec;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    vec_n   = vec;
    hold_n  = hold;
    pcnt_n  = pcnt;
    err_n   = err_count;
    ff_n    = first_fail;
    pass_n  = pass;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          vec_n   = 4'd0;
          hold_n  = 3'd0;
          pcnt_n  = 3'd0;
          err_n   = 5'd0;
          ff_n    = 4'd0;
          pass_n  = 1'b0;
        end
      end

      RUN: begin
        if (hold == LAT_C) begin
          if (mismatch) begin
            if (err_count != 5'd31) err_n = err_count + 5'd1;
            // The count never returns to zero within a run, so zero means
            // that this is the first mismatch.
            if (err_count == 5'd0)  ff_n  = vec;
          end
          vec_n  = vec + 4'd1;
          hold_n = 3'd0;
          if (vec == 4'd15) begin
            pcnt_n = pcnt + 3'd1;
            if (pcnt_n == PASS_C) begin
              state_n = DONE;
              // Use the post-comparison count, so that a mismatch on the
              // final vector is reflected in pass.
              pass_n  = (err_n == 5'd0);
            end
          end
        end else begin
          hold_n = hold + 3'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // values from before the edge, whatever order the statements are written in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= 4'd0;
      hold       <= 3'd0;
      pcnt       <= 3'd0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      pass       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      hold       <= hold_n;
      pcnt       <= pcnt_n;
      err_count  <= err_n;
      first_fail <= ff_n;
      pass       <= pass_n;
      // Registered status flags avoid decode glitches on the outputs.
      busy       <= (state_n == RUN);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_adder_bist_driver.sv
// ---------------------------------------------------------------------------
// tb_adder_bist_driver
//
// Five driver instances with different LATENCY/PASSES settings. Each instance
// faces a behavioural adder with a programmable delay and fault pattern:
//   resp = (sum(op) ^ xm[op]) & am
// Every run pushes its expected outcome into a scoreboard queue. The outcome
// is computed from a cycle timeline of the operands driven during the run.
// A monitor checks the operand stepping on every cycle and pops the queue
// each time a done flag rises.
// ---------------------------------------------------------------------------
module tb_adder_bist_driver;

  localparam int N = 5;
  localparam int LAT [N] = '{1, 1, 3, 2, 0};
  localparam int PAS [N] = '{1, 2, 1, 1, 4};
  localparam int DLY [N] = '{1, 1, 3, 3, 0};

  typedef struct {
    int         inst;
    logic [4:0] err;
    logic [3:0] ff;
    logic       pas;
    int         cycles;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       start_s [N];
  logic       rst_s   [N];
  logic [4:0] resp    [N];
  wire  [3:0] opnd    [N];
  wire        busy_s  [N];
  wire        done_s  [N];
  wire        pass_s  [N];
  wire  [4:0] err_s   [N];
  wire  [3:0] ff_s    [N];

  logic [4:0] xm   [N][16];
  logic [4:0] am   [N];
  logic [3:0] hist [N][8];

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wire [3:0] op_l;
    adder_bist_driver #(.LATENCY(LAT[g]), .PASSES(PAS[g])) u_dut (
      .clk(clk), .reset(rst_s[g]), .start(start_s[g]),
      .a(op_l[3]), .b(op_l[2]), .c(op_l[1]), .d(op_l[0]),
      .v(resp[g][4]), .w(resp[g][3]), .x(resp[g][2]), .y(resp[g][1]), .z(resp[g][0]),
      .busy(busy_s[g]), .done(done_s[g]), .pass(pass_s[g]),
      .err_count(err_s[g]), .first_fail(ff_s[g])
    );
    assign opnd[g] = op_l;
  end

  function automatic logic [4:0] golden(logic [3:0] op);
    return 5'(int'(op[3:2]) + int'(op[1:0]));
  endfunction

  // Adder models: history of operands, one entry per clock.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      hist[i][0] <= opnd[i];
      for (int k = 1; k < 8; k++) hist[i][k] <= hist[i][k-1];
    end
  end

  always_comb begin
    logic [3:0] src;
    src = 4'd0;
    for (int i = 0; i < N; i++) begin
      src     = (DLY[i] == 0) ? opnd[i] : hist[i][(DLY[i] == 0) ? 0 : DLY[i] - 1];
      resp[i] = (golden(src) ^ xm[i][src]) & am[i];
    end
  end

  // Reference: walk the run cycle by cycle. The operand at cycle t is
  // t/(LATENCY+1) mod 16, and it is 0 before the run starts. Each check sees
  // the operand from DLY cycles earlier, passed through the fault model.
  function automatic exp_t model(int inst);
    exp_t e;
    int   l, p, dl, n, t, src, opv;
    logic [4:0] r;
    l = LAT[inst]; p = PAS[inst]; dl = DLY[inst]; n = 0;
    e.inst = inst; e.ff = 4'd0;
    for (int k = 0; k < 16 * p; k++) begin
      t   = k * (l + 1) + l;
      src = t - dl;
      opv = (src < 0) ? 0 : (src / (l + 1)) % 16;
      r   = (golden(4'(opv)) ^ xm[inst][opv]) & am[inst];
      if (r != golden(4'(k % 16))) begin
        if (n == 0) e.ff = 4'(k % 16);
        n++;
      end
    end
    e.err    = (n > 31) ? 5'd31 : 5'(n);
    e.pas    = (n == 0);
    e.cycles = 16 * p * (l + 1);
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: checks the operand on every cycle; compares against the
  // scoreboard when done rises.
  int   cnt       [N];
  logic prev_done [N];
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; prev_done[i] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst_s[i]) begin
          cnt[i] = 0;
          prev_done[i] = 1'b0;
        end else begin
          if (busy_s[i]) begin
            check($sformatf("opnd_run_i%0d", i), opnd[i], (cnt[i] / (LAT[i] + 1)) % 16);
            cnt[i]++;
          end else begin
            check($sformatf("opnd_idle_i%0d", i), opnd[i], 0);
          end
          if (done_s[i] && !prev_done[i]) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_done_i%0d actual=done expected=no_pending_run", i);
            end else begin
              e = sb.pop_front();
              check($sformatf("sb_inst_i%0d", i),   i,         e.inst);
              check($sformatf("sb_cycles_i%0d", i), cnt[i],    e.cycles);
              check($sformatf("sb_err_i%0d", i),    err_s[i],  e.err);
              check($sformatf("sb_ff_i%0d", i),     ff_s[i],   e.ff);
              check($sformatf("sb_pass_i%0d", i),   pass_s[i], e.pas);
            end
            cnt[i] = 0;
          end
          prev_done[i] = done_s[i];
        end
      end
    end
  end

  task automatic set_faults(int inst, bit rnd, logic [4:0] and_mask);
    for (int k = 0; k < 16; k++)
      xm[inst][k] = (rnd && $urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    am[inst] = and_mask;
  endtask

  task automatic wait_done(int inst, int budget, string tag);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_s[inst]) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=done_low expected=done_high", tag);
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(4, 9)) @(posedge clk);
  endtask

  task automatic run(int inst, bit hold, string tag);
    exp_t e;
    e = model(inst);
    sb.push_back(e);
    if (hold) sb.push_back(e);
    @(posedge clk); #1 start_s[inst] = 1'b1;
    @(posedge clk); #1 if (!hold) start_s[inst] = 1'b0;
    wait_done(inst, e.cycles + 20, tag);
  endtask

  initial begin
    bit   got;
    int   inst;
    logic [4:0] amask;
    for (int i = 0; i < N; i++) begin
      start_s[i] = 1'b0; rst_s[i] = 1'b1;
      set_faults(i, 1'b0, 5'h1f);
    end
    #12;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_opnd_i%0d", i), opnd[i],   0);
      check($sformatf("rst_busy_i%0d", i), busy_s[i], 0);
      check($sformatf("rst_done_i%0d", i), done_s[i], 0);
      check($sformatf("rst_pass_i%0d", i), pass_s[i], 0);
      check($sformatf("rst_err_i%0d", i),  err_s[i],  0);
      check($sformatf("rst_ff_i%0d", i),   ff_s[i],   0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
    gap();

    // A correct adder with LATENCY=1 gives a clean 32-cycle run.
    run(0, 1'b0, "good_l1");
    check("good_pass", pass_s[0], 1);
    gap();

    // z stuck at 0 fails on every odd sum.
    set_faults(0, 1'b0, 5'b11110);
    run(0, 1'b0, "stuck_z");
    check("stuck_err", err_s[0], 8);
    check("stuck_ff",  ff_s[0],  1);
    check("stuck_pass", pass_s[0], 0);
    gap();

    set_faults(1, 1'b0, 5'b11110);
    run(1, 1'b0, "stuck_p2");
    check("stuck_p2_err", err_s[1], 16);
    check("stuck_p2_ff",  ff_s[1],  1);
    gap();

    // start held high throughout: no mid-run restart, then a restart
    // right after done.
    run(0, 1'b1, "held1");
    @(posedge clk); #1;
    check("restart_done_clr", done_s[0], 0);
    check("restart_err_clr",  err_s[0],  0);
    check("restart_busy",     busy_s[0], 1);
    start_s[0] = 1'b0;
    wait_done(0, 60, "held2");
    gap();

    // Reset in the middle of a run, then a fresh run.
    set_faults(0, 1'b0, 5'h1f);
    sb.push_back(model(0));
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (opnd[0] == 4'd7) begin got = 1'b1; break; end
    end
    check("reach_vec7", got, 1);
    #2 rst_s[0] = 1'b1;
    #1;
    check("abort_opnd", opnd[0],   0);
    check("abort_busy", busy_s[0], 0);
    check("abort_done", done_s[0], 0);
    check("abort_err",  err_s[0],  0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1 rst_s[0] = 1'b0;
    gap();
    run(0, 1'b0, "post_reset");
    check("post_reset_pass", pass_s[0], 1);
    gap();

    // Matched and mismatched latency against a 3-cycle adder.
    run(2, 1'b0, "lat3");
    check("lat3_pass", pass_s[2], 1);
    gap();
    run(3, 1'b0, "lat2_vs_3");
    check("lat2_pass", pass_s[3], 0);
    gap();

    // Every response wrong over 64 checks: the count saturates at 31.
    for (int k = 0; k < 16; k++) xm[4][k] = 5'b10000;
    run(4, 1'b0, "saturate");
    check("sat_err", err_s[4], 31);
    check("sat_ff",  ff_s[4],  0);
    gap();

    // Random fault patterns on random instances.
    for (int r = 0; r < 12; r++) begin
      inst  = $urandom_range(0, N - 1);
      amask = ($urandom_range(0, 3) == 0) ? ~(5'd1 << $urandom_range(0, 4)) : 5'h1f;
      set_faults(inst, 1'b1, amask);
      run(inst, 1'b0, $sformatf("rand%0d", r));
      gap();
    end

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bist_driver.md
# adder_bist_driver

Built-in self-test initiator for the top-level 2-bit adder. It drives the adder's operand bits `a`–`d` and checks its result bits `v`–`z`. On `start` it sweeps all 16 operand combinations, holding each for a fixed number of cycles to cover adder latency. It compares every sampled response against the expected sum and reports a pass flag, an error count and the first failing vector. It sits in the wrapper beside the adder instance, on the opposite side of the same a–d / v–z interface.

## Interface
Parameters:
- `LATENCY`, default 1: clock cycles from a new operand appearing on `a`–`d` to a valid response on `v`–`z`; legal range 0–7.
- `PASSES`, default 1: number of full 16-vector sweeps per run; legal range 1–4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `a`, `b`, `c`, `d`  out  1 each  operand drive, registered; operand A = {a,b}, operand B = {c,d}, MSB first.
- `v`, `w`, `x`, `y`, `z`  in  1 each  adder response, treated as {v,w,x,y,z} with v as MSB.
- `busy`  out  1  high while the sweep is running.
- `done`  out  1  high from run completion until the next accepted start or reset.
- `pass`  out  1  valid only while `done`=1; 1 = zero mismatches.
- `err_count`  out  5  mismatch count for the current run, saturating at 31.
- `first_fail`  out  4  {a,b,c,d} of the first mismatching vector; 0 if no mismatch.

## Operation
- Expected response: {v,w,x,y,z} == {2'b00, A+B}, where A+B is a 3-bit unsigned sum. All 5 bits are compared.
- States:
  - IDLE: reached on reset.
  - RUN.
  - DONE.
- Transitions:
  - IDLE → RUN on `start`=1.
  - RUN → DONE after the last check of the last pass.
  - DONE → RUN on `start`=1.
  - DONE holds otherwise.
- Accepting a start, on that clock edge:
  - vector index = 0, hold counter = 0, pass counter = 0.
  - `err_count` = 0, `first_fail` = 0, `done` = 0, `pass` = 0.
- RUN behaviour:
  - {a,b,c,d} = vector index.
  - The hold counter runs 0..LATENCY.
  - On the edge where hold counter == LATENCY, the response is sampled and compared, then the vector index increments (0..15, wrapping to 0) and the hold counter clears.
- Mismatch:
  - `err_count` increments, saturating at 31.
  - If this is the first mismatch of the run, `first_fail` captures the vector index.
- After vector 15 is checked:
  - Pass counter increments.
  - If the pass counter reaches PASSES, go to DONE. Otherwise continue from vector 0.
- In IDLE and DONE: `a`–`d` driven 0.
- `start` while `busy`=1 is ignored; it is neither queued nor a restart.

## Timing
- Reset values: `a`–`d` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `first_fail` = 0. State = IDLE.
- Assertion of `reset` mid-run aborts immediately and asynchronously to the reset values. There is no partial result.
- Start accepted on edge E:
  - `busy`=1 and vector 0 appear on `a`–`d` right after E.
  - Each vector is held for LATENCY+1 cycles.
- Run length: 16 × PASSES × (LATENCY+1) cycles from E.
  - `busy` falls and `done`/`pass` rise on the same edge as the final comparison.
  - `err_count` on that edge already includes the final comparison.
- With LATENCY=0 the response is compared combinationally against the vector driven in that same cycle.
- `pass` = (`err_count` == 0) and is updated only on entry to DONE.
- Simultaneous final mismatch and DONE entry: both the count and `first_fail` updates are visible when `done`=1.

## Test plan
- Correct adder model (LATENCY=1), `start` pulsed for one cycle:
  - `busy` high for 32 cycles.
  - `done`=1, `pass`=1, `err_count`=0, `first_fail`=0.
  - `a`–`d` step 0000→1111, each held 2 cycles.
- Adder model with `z` stuck at 0 (LATENCY=1):
  - `err_count`=8, `pass`=0.
  - `first_fail`=4'b0001 (A=0, B=1).
- PASSES=2 with the same stuck-at-0 fault: run takes 64 cycles, `err_count`=16, `first_fail`=4'b0001.
- `start` held high throughout a run: no restart mid-run. After `done`, the still-high `start` restarts on the next edge, and `done` and `err_count` clear.
- `reset` asserted at vector 7, then released and `start` issued with a correct model:
  - Outputs are 0 immediately on reset.
  - The fresh run completes with `pass`=1 and `err_count`=0.
- LATENCY=3 with an adder model delayed by 3 cycles: `pass`=1 after 64 cycles. The same model with LATENCY=2 gives `pass`=0.
